// File: rtl/fp_pkg.sv
// Shared floating-point adder definitions: exponent FSM states, default widths
// and the denormal effective-exponent rule used by the unpack and exponent logic.
package fp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_NORM  = 2'd2,
        S_DONE  = 2'd3
    } expo_state_t;

    localparam int EW_DEF    = 8;
    localparam int SW_DEF    = 5;
    localparam int SHMAX_DEF = 27;

    // Wide enough for fp32 and fp64 exponents; callers extend/truncate to their width.
    localparam int EXP_MAXW  = 16;

    // A zero (denormal) exponent behaves as exponent 1 for alignment.
    function automatic logic [EXP_MAXW-1:0] eff_exp(input logic [EXP_MAXW-1:0] e);
        return (e == '0) ? EXP_MAXW'(1) : e;
    endfunction

endpackage

// File: rtl/expo_cmp.sv
// Combinational exponent compare: larger raw exponent, swap decision and the
// saturated alignment shift derived from the effective exponents.
module expo_cmp
    import fp_pkg::*;
#(
    parameter int EW    = EW_DEF,
    parameter int SW    = SW_DEF,
    parameter int SHMAX = SHMAX_DEF
) (
    input  logic [EW-1:0] ea,
    input  logic [EW-1:0] eb,
    output logic [EW-1:0] max_e,
    output logic          swap,
    output logic [SW-1:0] shift
);

    localparam logic [EW-1:0] SHMAX_E = EW'(SHMAX);

    logic [EW-1:0] ea_eff;
    logic [EW-1:0] eb_eff;
    logic [EW-1:0] diff;

    always_comb begin
        ea_eff = EW'(eff_exp(EXP_MAXW'(ea)));
        eb_eff = EW'(eff_exp(EXP_MAXW'(eb)));
        max_e  = (eb > ea) ? eb : ea;
        swap   = (eb_eff > ea_eff);
        diff   = swap ? (eb_eff - ea_eff) : (ea_eff - eb_eff);
        shift  = (diff > SHMAX_E) ? SW'(SHMAX) : SW'(diff);
    end

endmodule

// File: rtl/expo_ctrl.sv
// Exponent control for the FP adder: loads the larger exponent, publishes the
// alignment shift, then applies saturating normalisation steps.
module expo_ctrl
    import fp_pkg::*;
#(
    parameter int EW    = EW_DEF,
    parameter int SW    = SW_DEF,
    parameter int SHMAX = SHMAX_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ldex,
    input  logic [EW-1:0] ea,
    input  logic [EW-1:0] eb,
    input  logic          ince,
    input  logic          dece,
    input  logic [SW-1:0] amt,
    input  logic          fin,
    output logic [EW-1:0] out_expo,
    output logic [SW-1:0] shift,
    output logic          swap,
    output logic          shift_valid,
    output logic          busy,
    output logic          out_valid,
    output logic          ovf,
    output logic          unf,
    output logic          special
);

    localparam logic [EW-1:0] EMAX   = '1;
    localparam logic [EW:0]   EMAX_X = {1'b0, EMAX};

    expo_state_t   state_q, state_d;
    logic [EW-1:0] expo_q, expo_d;
    logic [SW-1:0] shift_q, shift_d;
    logic          swap_q, swap_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          special_q, special_d;

    logic [EW-1:0] cmp_max;
    logic          cmp_swap;
    logic [SW-1:0] cmp_shift;
    logic [EW:0]   sum;
    logic [EW:0]   amt_x;
    logic          load;

    expo_cmp #(.EW(EW), .SW(SW), .SHMAX(SHMAX)) u_cmp (
        .ea    (ea),
        .eb    (eb),
        .max_e (cmp_max),
        .swap  (cmp_swap),
        .shift (cmp_shift)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            expo_q    <= '0;
            shift_q   <= '0;
            swap_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            expo_q    <= expo_d;
            shift_q   <= shift_d;
            swap_q    <= swap_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            special_q <= special_d;
        end
    end

    assign load = ldex && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ldex) state_d = S_ALIGN;
            S_ALIGN: state_d = special_q ? S_DONE : S_NORM;
            S_NORM:  if (fin) state_d = S_DONE;
            S_DONE:  state_d = ldex ? S_ALIGN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sum and compare in EW+1 bits so the carry out of the increment is visible.
    always_comb begin
        expo_d    = expo_q;
        shift_d   = shift_q;
        swap_d    = swap_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        special_d = special_q;
        amt_x     = (EW+1)'(amt);
        sum       = {1'b0, expo_q} + amt_x;
        if (load) begin
            expo_d    = cmp_max;
            shift_d   = cmp_shift;
            swap_d    = cmp_swap;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
            special_d = (ea == EMAX) || (eb == EMAX);
        end else if (state_q == S_NORM) begin
            if (ince) begin
                if (amt != '0) begin
                    if (sum >= EMAX_X) begin
                        expo_d = EMAX;
                        ovf_d  = 1'b1;
                    end else begin
                        expo_d = sum[EW-1:0];
                    end
                end
            end else if (dece && (amt != '0)) begin
                if ({1'b0, expo_q} <= amt_x) begin
                    expo_d = '0;
                    unf_d  = 1'b1;
                end else begin
                    expo_d = expo_q - EW'(amt);
                end
            end
        end
    end

    always_comb begin
        shift_valid = (state_q == S_ALIGN);
        out_valid   = (state_q == S_DONE);
        busy        = (state_q != S_IDLE);
        out_expo    = expo_q;
        shift       = shift_q;
        swap        = swap_q;
        ovf         = ovf_q;
        unf         = unf_q;
        special     = special_q;
    end

endmodule

// File: tb/tb_expo_ctrl.sv
// Directed bench for expo_ctrl: hand-computed exponents, shifts, strobes and
// flags checked with immediate assertions along one linear stimulus sequence.
module tb_expo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ldex;
    logic [7:0] ea, eb;
    logic       ince, dece;
    logic [4:0] amt;
    logic       fin;
    logic [7:0] out_expo;
    logic [4:0] shift;
    logic       swap, shift_valid, busy, out_valid, ovf, unf, special;

    int checks = 0;
    int errors = 0;

    expo_ctrl #(.EW(8), .SW(5), .SHMAX(27)) dut (
        .clk         (clk),
        .reset       (reset),
        .ldex        (ldex),
        .ea          (ea),
        .eb          (eb),
        .ince        (ince),
        .dece        (dece),
        .amt         (amt),
        .fin         (fin),
        .out_expo    (out_expo),
        .shift       (shift),
        .swap        (swap),
        .shift_valid (shift_valid),
        .busy        (busy),
        .out_valid   (out_valid),
        .ovf         (ovf),
        .unf         (unf),
        .special     (special)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " expo"},  32'(out_expo), 32'h0);
        chk({tag, " shift"}, 32'(shift), 32'h0);
        chk({tag, " swap"},  32'(swap), 32'h0);
        chk({tag, " sv"},    32'(shift_valid), 32'h0);
        chk({tag, " busy"},  32'(busy), 32'h0);
        chk({tag, " ov"},    32'(out_valid), 32'h0);
        chk({tag, " ovf"},   32'(ovf), 32'h0);
        chk({tag, " unf"},   32'(unf), 32'h0);
        chk({tag, " spec"},  32'(special), 32'h0);
    endtask

    initial begin
        reset = 1'b1; ldex = 1'b0; ea = '0; eb = '0;
        ince = 1'b0; dece = 1'b0; amt = '0; fin = 1'b0;
        step(); step();
        chk_zero("rst");
        reset = 1'b0;
        step();

        // 1: A larger
        ldex = 1'b1; ea = 8'h85; eb = 8'h80;
        step();
        ldex = 1'b0;
        chk("t1 expo", 32'(out_expo), 32'h85);
        chk("t1 shift", 32'(shift), 32'd5);
        chk("t1 swap", 32'(swap), 32'd0);
        chk("t1 sv", 32'(shift_valid), 32'd1);
        chk("t1 busy", 32'(busy), 32'd1);
        step();
        chk("t1 sv off", 32'(shift_valid), 32'd0);
        chk("t1 norm ov", 32'(out_valid), 32'd0);
        chk("t1 norm busy", 32'(busy), 32'd1);
        fin = 1'b1;
        step();
        fin = 1'b0;
        chk("t1 done ov", 32'(out_valid), 32'd1);
        chk("t1 done expo", 32'(out_expo), 32'h85);
        step();
        chk("t1 idle busy", 32'(busy), 32'd0);
        chk("t1 idle ov", 32'(out_valid), 32'd0);

        // 2: denormal A, shift saturates (1 vs 0x40 -> 63 -> 27)
        ldex = 1'b1; ea = 8'h00; eb = 8'h40;
        step();
        ldex = 1'b0;
        chk("t2 swap", 32'(swap), 32'd1);
        chk("t2 shift", 32'(shift), 32'd27);
        chk("t2 expo", 32'(out_expo), 32'h40);
        step();
        fin = 1'b1;
        step();
        fin = 1'b0;
        step();

        // 3: normalise down into underflow
        ldex = 1'b1; ea = 8'h03; eb = 8'h01;
        step();
        ldex = 1'b0;
        chk("t3 shift", 32'(shift), 32'd2);
        step();
        dece = 1'b1; amt = 5'd2;
        step();
        chk("t3 dec2", 32'(out_expo), 32'h01);
        chk("t3 unf0", 32'(unf), 32'd0);
        amt = 5'd1;
        step();
        chk("t3 dec1", 32'(out_expo), 32'h00);
        chk("t3 unf1", 32'(unf), 32'd1);
        dece = 1'b0; fin = 1'b1;
        step();
        fin = 1'b0;
        chk("t3 done ov", 32'(out_valid), 32'd1);
        chk("t3 done expo", 32'(out_expo), 32'h00);
        step();
        chk("t3 unf hold", 32'(unf), 32'd1);

        // 4: overflow saturation
        ldex = 1'b1; ea = 8'hFD; eb = 8'h10;
        step();
        ldex = 1'b0;
        chk("t4 unf clr", 32'(unf), 32'd0);
        chk("t4 spec", 32'(special), 32'd0);
        step();
        ince = 1'b1; amt = 5'd1;
        step();
        chk("t4 inc1", 32'(out_expo), 32'hFE);
        chk("t4 ovf0", 32'(ovf), 32'd0);
        amt = 5'd3;
        step();
        chk("t4 inc3", 32'(out_expo), 32'hFF);
        chk("t4 ovf1", 32'(ovf), 32'd1);
        dece = 1'b1; amt = 5'd2;
        step();
        chk("t4 both", 32'(out_expo), 32'hFF);
        chk("t4 both unf", 32'(unf), 32'd0);
        ince = 1'b0; amt = 5'd5;
        step();
        chk("t4 dec5", 32'(out_expo), 32'hFA);
        chk("t4 ovf stick", 32'(ovf), 32'd1);
        dece = 1'b0; ince = 1'b1; amt = 5'd0;
        step();
        chk("t4 amt0", 32'(out_expo), 32'hFA);
        ince = 1'b0; fin = 1'b1;
        step();
        fin = 1'b0;
        step();

        // 5: special operand bypasses NORM; ince in ALIGN ignored
        ldex = 1'b1; ea = 8'hFF; eb = 8'h10;
        step();
        ldex = 1'b0; ince = 1'b1; amt = 5'd1;
        chk("t5 spec", 32'(special), 32'd1);
        chk("t5 sv", 32'(shift_valid), 32'd1);
        chk("t5 expo", 32'(out_expo), 32'hFF);
        chk("t5 shift", 32'(shift), 32'd27);
        chk("t5 ovf clr", 32'(ovf), 32'd0);
        step();
        chk("t5 ov N+2", 32'(out_valid), 32'd1);
        chk("t5 ovf ign", 32'(ovf), 32'd0);
        chk("t5 expo hold", 32'(out_expo), 32'hFF);
        step();
        ince = 1'b0;
        chk("t5 idle", 32'(busy), 32'd0);
        chk("t5 spec hold", 32'(special), 32'd1);

        // 6: reset mid-NORM, then back-to-back load from DONE
        ldex = 1'b1; ea = 8'h20; eb = 8'h22;
        step();
        ldex = 1'b0;
        chk("t6 swap", 32'(swap), 32'd1);
        chk("t6 shift", 32'(shift), 32'd2);
        step();
        ince = 1'b1; amt = 5'd4;
        step();
        ince = 1'b0;
        chk("t6 inc4", 32'(out_expo), 32'h26);
        reset = 1'b1;
        #2;
        chk_zero("t6 rst");
        reset = 1'b0;
        ldex = 1'b1; ea = 8'hFD; eb = 8'h01;
        step();
        ldex = 1'b0;
        chk("t6 load", 32'(out_expo), 32'hFD);
        chk("t6 sv", 32'(shift_valid), 32'd1);
        step();
        ince = 1'b1; amt = 5'd5;
        step();
        ince = 1'b0;
        chk("t6 ovf", 32'(ovf), 32'd1);
        chk("t6 sat", 32'(out_expo), 32'hFF);
        fin = 1'b1;
        step();
        fin = 1'b0;
        chk("t6 done", 32'(out_valid), 32'd1);
        ldex = 1'b1; ea = 8'h30; eb = 8'h10;
        step();
        ldex = 1'b0;
        chk("t6 b2b sv", 32'(shift_valid), 32'd1);
        chk("t6 b2b ovf", 32'(ovf), 32'd0);
        chk("t6 b2b expo", 32'(out_expo), 32'h30);
        chk("t6 b2b shift", 32'(shift), 32'd27);
        chk("t6 b2b swap", 32'(swap), 32'd0);
        step();
        chk("t6 b2b norm", 32'(busy), 32'd1);
        chk("t6 b2b ov", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
